md_issue_ctrl: RTL and testbench

- Initiator side of the hi/lo multiply-divide interface. Sits between the decode/execute stage and the md unit.
- Accepts mult/multu/div/divu/mthi/mtlo requests from the datapath, then holds the md operands and control stable.
- Drives the start_mult/start_div/updatemd/md_control handshake and tracks completion using the md unit's busy count plus an internal latency counter.
- Raises a stall to the CPU while any hi/lo access would race an in-flight operation.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the hi/lo multiply-divide interface: op_sel
// encodings, issue FSM state encodings and default md latencies.
package md_pkg;

    // op_sel encodings presented by the datapath
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    // Issue FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Default md unit occupancy after the start pulse, shared with hazard logic
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    function automatic logic is_mult(input logic [2:0] sel);
        return (sel == MD_MULT) || (sel == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] sel);
        return (sel == MD_DIV) || (sel == MD_DIVU);
    endfunction

    function automatic logic is_legal(input logic [2:0] sel);
        return is_mult(sel) || is_div(sel) || (sel == MD_MTHI) || (sel == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Initiator side of the hi/lo multiply-divide interface. Accepts md-class
// requests in IDLE, pulses the md start for one ISSUE cycle, then holds
// operands and updatemd through WAIT until the md unit has finished. Any
// hi/lo access or new md request while not idle stalls the pipeline front.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        op_valid,
    input  logic [2:0]  op_sel,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    input  logic        mf_req,
    input  logic [3:0]  md_busy,
    output logic        op_accept,
    output logic        stall,
    output logic        illegal_op,
    output logic        start_mult,
    output logic        start_div,
    output logic        updatemd,
    output logic [2:0]  md_control,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             start_mult_q, start_mult_d;
    logic             start_div_q, start_div_d;
    logic             updatemd_q, updatemd_d;
    logic [2:0]       md_control_q, md_control_d;
    logic [31:0]      md_rs_q, md_rs_d;
    logic [31:0]      md_rt_q, md_rt_d;

    logic in_idle;
    logic sel_legal;

    assign in_idle   = (state_q == ST_IDLE);
    assign sel_legal = is_legal(op_sel);
    assign op_accept = in_idle & op_valid & sel_legal;
    assign stall     = ~in_idle & (op_valid | mf_req);

    assign illegal_op = illegal_q;
    assign start_mult = start_mult_q;
    assign start_div  = start_div_q;
    assign updatemd   = updatemd_q;
    assign md_control = md_control_q;
    assign md_rs      = md_rs_q;
    assign md_rt      = md_rt_q;

    // Next-state logic; cnt_q holds the WAIT cycles still owed, including the current one
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        illegal_d    = 1'b0;
        start_mult_d = 1'b0;
        start_div_d  = 1'b0;
        updatemd_d   = 1'b0;
        md_control_d = md_control_q;
        md_rs_d      = md_rs_q;
        md_rt_d      = md_rt_q;
        case (state_q)
            ST_IDLE: begin
                if (op_accept) begin
                    state_d      = ST_ISSUE;
                    md_control_d = op_sel;
                    md_rs_d      = op_rs;
                    md_rt_d      = op_rt;
                    start_mult_d = is_mult(op_sel);
                    start_div_d  = is_div(op_sel);
                    updatemd_d   = 1'b1;
                end else if (op_valid && !sel_legal) begin
                    illegal_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (is_mult(md_control_q)) begin
                    state_d    = ST_WAIT;
                    cnt_d      = CNT_W'(MULT_LAT);
                    updatemd_d = 1'b1;
                end else if (is_div(md_control_q)) begin
                    state_d    = ST_WAIT;
                    cnt_d      = CNT_W'(DIV_LAT);
                    updatemd_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
                if ((cnt_q <= CNT_W'(1)) && (md_busy == 4'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    updatemd_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            illegal_q    <= 1'b0;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            updatemd_q   <= 1'b0;
            md_control_q <= 3'b000;
            md_rs_q      <= 32'd0;
            md_rt_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            illegal_q    <= illegal_d;
            start_mult_q <= start_mult_d;
            start_div_q  <= start_div_d;
            updatemd_q   <= updatemd_d;
            md_control_q <= md_control_d;
            md_rs_q      <= md_rs_d;
            md_rt_q      <= md_rt_d;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model and a
// small md-unit responder that produces md_busy and hi/lo.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        op_valid;
    logic [2:0]  op_sel;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        mf_req;
    logic [3:0]  md_busy;
    logic        op_accept;
    logic        stall;
    logic        illegal_op;
    logic        start_mult;
    logic        start_div;
    logic        updatemd;
    logic [2:0]  md_control;
    logic [31:0] md_rs;
    logic [31:0] md_rt;

    md_issue_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .op_valid  (op_valid),
        .op_sel    (op_sel),
        .op_rs     (op_rs),
        .op_rt     (op_rt),
        .mf_req    (mf_req),
        .md_busy   (md_busy),
        .op_accept (op_accept),
        .stall     (stall),
        .illegal_op(illegal_op),
        .start_mult(start_mult),
        .start_div (start_div),
        .updatemd  (updatemd),
        .md_control(md_control),
        .md_rs     (md_rs),
        .md_rt     (md_rt)
    );

    always #5 Clk = ~Clk;

    int compareCount = 0;
    int failCount    = 0;

    // md unit responder state
    int          mdBusyCnt   = 0;
    int          mdExtra     = 0;
    logic [31:0] hiReg       = 32'd0;
    logic [31:0] loReg       = 32'd0;
    bit          sawStart    = 1'b0;
    bit          sawMult     = 1'b0;
    int          startDivCount = 0;

    // Reference model: busy flag plus age since the ISSUE cycle
    bit          mBusy    = 1'b0;
    int          mAge     = 0;
    logic [2:0]  mOp      = 3'd0;
    logic [2:0]  mCtl     = 3'd0;
    logic [31:0] mRs      = 32'd0;
    logic [31:0] mRt      = 32'd0;
    bit          mIllegal = 1'b0;

    bit lastStall  = 1'b0;
    bit lastAccept = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit legal;
        bit expStall;
        bit expAccept;
        bit expStartMult;
        bit expStartDiv;
        int lat;
        longint prod;
        legal        = (op_sel <= 3'd5);
        expStall     = mBusy && (op_valid || mf_req);
        expAccept    = !mBusy && op_valid && legal;
        expStartMult = mBusy && (mAge == 0) && (mOp < 3'd2);
        expStartDiv  = mBusy && (mAge == 0) && (mOp == 3'd2 || mOp == 3'd3);

        checkValue("op_accept",  32'(op_accept),  32'(expAccept));
        checkValue("stall",      32'(stall),      32'(expStall));
        checkValue("start_mult", 32'(start_mult), 32'(expStartMult));
        checkValue("start_div",  32'(start_div),  32'(expStartDiv));
        checkValue("updatemd",   32'(updatemd),   32'(mBusy));
        checkValue("illegal_op", 32'(illegal_op), 32'(mIllegal));
        checkValue("md_control", 32'(md_control), 32'(mCtl));
        checkValue("md_rs",      md_rs,           mRs);
        checkValue("md_rt",      md_rt,           mRt);

        lastStall  = stall;
        lastAccept = op_accept;

        // md unit view of the handshake
        sawStart = start_mult || start_div;
        sawMult  = start_mult;
        if (start_div) startDivCount++;
        if (updatemd) begin
            case (md_control)
                3'd0: begin
                    prod  = longint'($signed(md_rs)) * longint'($signed(md_rt));
                    hiReg = prod[63:32];
                    loReg = prod[31:0];
                end
                3'd1: begin
                    prod  = longint'({32'd0, md_rs}) * longint'({32'd0, md_rt});
                    hiReg = prod[63:32];
                    loReg = prod[31:0];
                end
                3'd2: if (md_rt != 32'd0) begin
                    loReg = $signed(md_rs) / $signed(md_rt);
                    hiReg = $signed(md_rs) % $signed(md_rt);
                end
                3'd3: if (md_rt != 32'd0) begin
                    loReg = md_rs / md_rt;
                    hiReg = md_rs % md_rt;
                end
                3'd4: hiReg = md_rs;
                3'd5: loReg = md_rs;
                default: ;
            endcase
        end

        // Advance the reference model across the coming edge
        if (Reset) begin
            mBusy    = 1'b0;
            mAge     = 0;
            mCtl     = 3'd0;
            mRs      = 32'd0;
            mRt      = 32'd0;
            mIllegal = 1'b0;
        end else begin
            mIllegal = !mBusy && op_valid && !legal;
            if (!mBusy) begin
                if (op_valid && legal) begin
                    mBusy = 1'b1;
                    mAge  = 0;
                    mOp   = op_sel;
                    mCtl  = op_sel;
                    mRs   = op_rs;
                    mRt   = op_rt;
                end
            end else begin
                lat = (mOp < 3'd2) ? MULT_LAT : (mOp < 3'd4) ? DIV_LAT : 0;
                if (mOp >= 3'd4) mBusy = 1'b0;
                else if (mAge >= lat && md_busy == 4'd0) mBusy = 1'b0;
                else mAge++;
            end
        end
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge
    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic mf, input logic rst);
        Reset    = rst;
        op_valid = v;
        op_sel   = sel;
        op_rs    = rs;
        op_rt    = rt;
        mf_req   = mf;
        @(negedge Clk);
        checkOutput();
        @(posedge Clk);
        #1;
        if (Reset) mdBusyCnt = 0;
        else if (sawStart) mdBusyCnt = (sawMult ? MULT_LAT : DIV_LAT) + mdExtra - 1;
        else if (mdBusyCnt > 0) mdBusyCnt--;
        md_busy = 4'(mdBusyCnt);
    endtask

    initial begin
        int n;
        bit accepted;
        Reset = 1'b1; op_valid = 1'b0; op_sel = 3'd0; op_rs = 32'd0; op_rt = 32'd0;
        mf_req = 1'b0; md_busy = 4'd0;
        @(posedge Clk);
        #1;
        $display("[TB] reset");
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        applyStimulus(0, 3'd0, 0, 0, 1, 0);

        $display("[TB] mult");
        applyStimulus(1, 3'b000, 32'hFFFFFFFE, 32'd3, 0, 0);
        checkValue("mult_accept", 32'(lastAccept), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 3'd0, 0, 0, 1, 0);
            if (lastStall) n++; else break;
        end
        checkValue("mult_stall_cycles", n, 6);
        checkValue("mult_hi", hiReg, 32'hFFFFFFFF);
        checkValue("mult_lo", loReg, 32'hFFFFFFFA);

        $display("[TB] divu slow md");
        mdExtra = 3;
        applyStimulus(1, 3'b011, 32'd100, 32'd7, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 3'd0, 0, 0, 1, 0);
            if (lastStall) n++; else break;
        end
        mdExtra = 0;
        checkValue("divu_stall_cycles", n, 14);
        checkValue("divu_hi", hiReg, 32'd2);
        checkValue("divu_lo", loReg, 32'd14);

        $display("[TB] mtlo then mf");
        applyStimulus(1, 3'b101, 32'h12345678, 32'd0, 0, 0);
        applyStimulus(0, 3'd0, 0, 0, 0, 0);
        applyStimulus(0, 3'd0, 0, 0, 1, 0);
        checkValue("mtlo_mf_stall", 32'(lastStall), 32'd0);
        checkValue("mtlo_lo", loReg, 32'h12345678);

        $display("[TB] collision");
        startDivCount = 0;
        applyStimulus(1, 3'b000, 32'd7, 32'd6, 1, 0);
        applyStimulus(0, 3'd0, 0, 0, 1, 0);
        n = 0;
        accepted = 1'b0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            applyStimulus(1, 3'b010, 32'd50, 32'd5, 0, 0);
            n++;
            accepted = lastAccept;
        end
        checkValue("collision_div_accept_step", n, 6);
        for (int i = 0; i < 16; i++) applyStimulus(0, 3'd0, 0, 0, 0, 0);
        checkValue("collision_start_div_count", startDivCount, 1);
        checkValue("collision_lo", loReg, 32'd10);
        checkValue("collision_hi", hiReg, 32'd0);

        $display("[TB] illegal");
        applyStimulus(1, 3'b111, 32'd1, 32'd2, 0, 0);
        checkValue("illegal_accept", 32'(lastAccept), 32'd0);
        applyStimulus(0, 3'd0, 0, 0, 0, 0);
        applyStimulus(0, 3'd0, 0, 0, 0, 0);

        $display("[TB] reset mid-wait");
        applyStimulus(1, 3'b000, 32'd9, 32'd9, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 3'd0, 0, 0, 0, 0);
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        applyStimulus(0, 3'd0, 0, 0, 1, 0);
        checkValue("reset_mf_stall", 32'(lastStall), 32'd0);

        $display("[TB] random");
        for (int i = 0; i < 300; i++) begin
            mdExtra = $urandom_range(0, 3);
            applyStimulus(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          ($urandom_range(0, 1) == 0), ($urandom_range(0, 99) == 0));
        end
        mdExtra = 0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 3'd0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
